// File: rtl/ssram_port_arbiter_pkg.sv
// Shared definitions for the SSRAM port arbiter: data width, owner encoding
// used by the exclusivity check, and the write payload routed to the macro.
package ssram_port_arbiter_pkg;

    localparam int unsigned SSRAM_DW = 32;
    localparam int unsigned SSRAM_BW = SSRAM_DW / 8;

    // Owner encoding of the macro in a given cycle
    localparam bit SSRAM_PORT_AHB = 1'b0;
    localparam bit SSRAM_PORT_AUX = 1'b1;

    // Write-side payload presented to the macro by either port
    typedef struct packed {
        logic                we;
        logic [SSRAM_BW-1:0] wbe;
        logic [SSRAM_DW-1:0] wdata;
    } ssram_wr_t;

    // Byte enables only reach the macro on writes
    function automatic logic [SSRAM_BW-1:0] gate_wbe(input logic we,
                                                     input logic [SSRAM_BW-1:0] wb);
        return we ? wb : '0;
    endfunction

endpackage

// File: rtl/ssram_port_arbiter_if.sv
// Bundle of bridge, aux requester, statistics and macro signals around the
// arbiter. slave = arbiter view, master = surrounding environment view.
interface ssram_port_arbiter_if
    import ssram_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = 12,
    parameter int unsigned CW = 16
);
    // bridge port
    logic [AW-1:0]       ahb_sram_addr;
    logic                ahb_sram_en;
    logic [SSRAM_BW-1:0] ahb_sram_enb;
    logic [SSRAM_BW-1:0] ahb_sram_wb;
    logic                ahb_sram_we;
    logic [SSRAM_DW-1:0] ahb_sram_din;
    logic [SSRAM_DW-1:0] sram_ahb_dout;
    // aux port
    logic                aux_req;
    logic                aux_we;
    logic [AW-1:0]       aux_addr;
    logic [SSRAM_BW-1:0] aux_wb;
    logic [SSRAM_DW-1:0] aux_wdata;
    logic                aux_gnt;
    logic                aux_rvalid;
    logic [SSRAM_DW-1:0] aux_rdata;
    // statistics
    logic                stat_clr;
    logic [CW-1:0]       stat_conflicts;
    // macro
    logic                mem_cs;
    logic                mem_we;
    logic [SSRAM_BW-1:0] mem_wbe;
    logic [AW-1:0]       mem_addr;
    logic [SSRAM_DW-1:0] mem_wdata;
    logic [SSRAM_DW-1:0] mem_rdata;

    modport slave (
        input  ahb_sram_addr, ahb_sram_en, ahb_sram_enb, ahb_sram_wb,
               ahb_sram_we, ahb_sram_din,
        output sram_ahb_dout,
        input  aux_req, aux_we, aux_addr, aux_wb, aux_wdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        input  stat_clr,
        output stat_conflicts,
        output mem_cs, mem_we, mem_wbe, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ahb_sram_addr, ahb_sram_en, ahb_sram_enb, ahb_sram_wb,
               ahb_sram_we, ahb_sram_din,
        input  sram_ahb_dout,
        output aux_req, aux_we, aux_addr, aux_wb, aux_wdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        output stat_clr,
        input  stat_conflicts,
        input  mem_cs, mem_we, mem_wbe, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/ssram_port_arbiter_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
// Ports: HCLK, HRESETn, inc (count this cycle), clr (zero next cycle), cnt.
module ssram_port_arbiter_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_nxt_c;

    // next count: clear, saturating increment, or hold
    always_comb begin
        cnt_nxt_c = cnt;
        if (clr) begin
            cnt_nxt_c = '0;
        end else if (inc && (cnt != '1)) begin
            cnt_nxt_c = cnt + W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/ssram_port_arbiter.sv
// Shares one single-port SSRAM macro between the AHB bridge (absolute
// priority, never stalled) and an aux req/gnt requester with one-cycle read
// return. Counts cycles where aux was blocked by the bridge.
// Ports: HCLK, HRESETn, bus (slave view: bridge, aux, stat and macro sides).
module ssram_port_arbiter
    import ssram_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = 12,
    parameter int unsigned CW = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ssram_port_arbiter_if.slave bus
);

    logic                ahb_win_c;
    logic                aux_gnt_c;
    logic                owner_c;
    logic                conflict_c;
    ssram_wr_t           ahb_wr_c;
    ssram_wr_t           aux_wr_c;
    ssram_wr_t           mem_wr_c;
    logic                rd_aux_r;
    logic                rd_ahb_r;
    logic [SSRAM_DW-1:0] aux_rdata_q;
    logic                unused_c;

    // arbitration: bridge always wins, aux only on idle bridge cycles
    assign ahb_win_c  = bus.ahb_sram_en;
    assign aux_gnt_c  = bus.aux_req & ~bus.ahb_sram_en;
    assign owner_c    = aux_gnt_c ? SSRAM_PORT_AUX : SSRAM_PORT_AHB;
    assign conflict_c = bus.aux_req & bus.ahb_sram_en;

    // per-port write payloads and owner select
    always_comb begin
        ahb_wr_c = '{we:    bus.ahb_sram_we,
                     wbe:   gate_wbe(bus.ahb_sram_we, bus.ahb_sram_wb),
                     wdata: bus.ahb_sram_din};
        aux_wr_c = '{we:    bus.aux_we,
                     wbe:   gate_wbe(bus.aux_we, bus.aux_wb),
                     wdata: bus.aux_wdata};
        mem_wr_c = (owner_c == SSRAM_PORT_AUX) ? aux_wr_c : ahb_wr_c;
    end

    // idle cycles leave address/data on the bridge values
    assign bus.mem_cs    = ahb_win_c | aux_gnt_c;
    assign bus.mem_we    = bus.mem_cs & mem_wr_c.we;
    assign bus.mem_wbe   = bus.mem_cs ? mem_wr_c.wbe : '0;
    assign bus.mem_addr  = (owner_c == SSRAM_PORT_AUX) ? bus.aux_addr : bus.ahb_sram_addr;
    assign bus.mem_wdata = mem_wr_c.wdata;

    // read-return tracking and aux data capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_aux_r    <= 1'b0;
            rd_ahb_r    <= 1'b0;
            aux_rdata_q <= '0;
        end else begin
            rd_aux_r <= aux_gnt_c & ~bus.aux_we;
            rd_ahb_r <= ahb_win_c & ~bus.ahb_sram_we;
            if (rd_aux_r) begin
                aux_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // bridge samples macro data only in its own data phase
    assign bus.sram_ahb_dout = bus.mem_rdata;
    assign bus.aux_gnt       = aux_gnt_c;
    assign bus.aux_rvalid    = rd_aux_r;
    // live data in the return cycle, last read value afterwards
    assign bus.aux_rdata     = rd_aux_r ? bus.mem_rdata : aux_rdata_q;

    // byte lanes are implied by the strobes; bridge read tracking is observational
    assign unused_c = ^{bus.ahb_sram_enb, rd_ahb_r};

    ssram_port_arbiter_sat_counter #(.W(CW)) u_conflicts (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .inc     (conflict_c),
        .clr     (bus.stat_clr),
        .cnt     (bus.stat_conflicts)
    );

    // the bridge owning the macro excludes an aux grant in the same cycle
    a_single_owner: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(ahb_win_c && (owner_c == SSRAM_PORT_AUX)));

endmodule

// File: doc/ssram_port_arbiter.md
Name: ssram_port_arbiter

Overview:
Sits directly downstream of the AHB-to-SSRAM bridge. It owns the single-port synchronous SRAM macro and shares it between the bridge port and an auxiliary requester port (DMA or debug loader). The bridge port has absolute priority because the bridge cannot be stalled from the SRAM side. The aux port uses a req/gnt handshake with a one-cycle read return. A saturating contention counter is provided for performance tuning.

Parameters:
AW, 12, word/byte address width, identical to the bridge's AW; passed through to the macro unchanged
CW, 16, contention counter width

Ports:
HCLK  input  1  clock; all flops rise on posedge
HRESETn  input  1  asynchronous active-low reset
ahb_sram_addr  input  AW  bridge address
ahb_sram_en  input  1  bridge access this cycle
ahb_sram_enb  input  4  bridge byte lanes (unused for reads; lint waiver)
ahb_sram_wb  input  4  bridge write byte strobes
ahb_sram_we  input  1  bridge write
ahb_sram_din  input  32  bridge write data
sram_ahb_dout  output  32  read data to bridge
aux_req  input  1  aux request; fields below held stable until aux_gnt
aux_we  input  1  aux write
aux_addr  input  AW  aux address
aux_wb  input  4  aux write byte strobes
aux_wdata  input  32  aux write data
aux_gnt  output  1  aux access issued to macro this cycle
aux_rvalid  output  1  aux read data valid (cycle after read grant)
aux_rdata  output  32  aux read data
stat_clr  input  1  synchronous clear of contention counter
stat_conflicts  output  CW  cycles with aux_req high while bridge owned the macro
mem_cs  output  1  macro chip select
mem_we  output  1  macro write enable
mem_wbe  output  4  macro byte write enables
mem_addr  output  AW  macro address
mem_wdata  output  32  macro write data
mem_rdata  input  32  macro read data, one cycle after a read select

Behaviour:
- Arbitration is combinational, evaluated every cycle.
  - ahb_win = ahb_sram_en.
  - aux_gnt = aux_req & ~ahb_sram_en.
- Macro mux:
  - When ahb_win: mem_* = bridge signals; mem_wbe = ahb_sram_wb when ahb_sram_we, else 0.
  - When aux_gnt: mem_* = aux signals; mem_wbe = aux_wb when aux_we, else 0.
  - Otherwise: mem_cs=0, mem_we=0, mem_wbe=0; mem_addr and mem_wdata hold the bridge values (don't-care).
- Read return:
  - Flops rd_aux_r <= aux_gnt & ~aux_we; rd_ahb_r <= ahb_win & ~ahb_sram_we.
  - sram_ahb_dout = mem_rdata at all times. The bridge samples it only in its data phase.
  - aux_rvalid = rd_aux_r.
  - aux_rdata = rd_aux_r ? mem_rdata : aux_rdata_q. aux_rdata_q loads mem_rdata whenever rd_aux_r is high, so read data stays stable until the next aux read.
- Aux writes complete in the grant cycle; no response is returned.
- Aux handshake:
  - The requester may drop aux_req only after aux_gnt.
  - Back-to-back grants are allowed on consecutive cycles.
  - A read grant followed by a grant to the same address returns the old data.
- Contention counter:
  - Increments each cycle aux_req & ahb_sram_en, and saturates at all-ones.
  - stat_clr has priority over increment; the count is 0 in the cycle after stat_clr.
- Same-cycle write/read hazard is impossible: one macro access per cycle.
  - A bridge write followed by an aux read of the same word returns the new data.
- Starvation: aux has no guarantee. A continuous bridge stream starves aux by design; stat_conflicts exposes it.
- Reset values: rd_aux_r=0, rd_ahb_r=0, aux_rdata_q=0, stat_conflicts=0.
  - The combinational outputs follow their inputs; with all requests low, mem_cs=0, aux_gnt=0, aux_rvalid=0.
- Reset asserted mid-read: aux_rvalid drops immediately. The pending read is lost and the requester must reissue it.

Decomposition:
- Shared package ahb_params.v (already included by AHB blocks) gains localparams:
  - SSRAM_PORT_AHB=0, SSRAM_PORT_AUX=1, used for the owner encoding in assertions.
  - SSRAM_DW=32.
- One natural sub-module: sat_counter (width CW; inc and clr inputs; clr priority; saturating). It is reusable by other stat blocks.
- Everything else stays flat.

Test Plan:
- Aux read alone: aux_req=1, aux_we=0, aux_addr=0x010, macro holds 0xDEADBEEF → aux_gnt=1 same cycle, mem_cs=1; next cycle aux_rvalid=1, aux_rdata=0xDEADBEEF, held after rvalid drops.
- Aux write then read: write aux_wb=4'b0101, aux_wdata=0x11223344 to a word preloaded 0xAABBCCDD, then read it back → 0xAA22CC44.
- Collision: aux_req held for 3 cycles with ahb_sram_en=1 for the first 2 → aux_gnt only in cycle 3; stat_conflicts=2; bridge write lands unchanged.
- Bridge write then aux read of same word 0x020 with ahb_sram_wb=4'hF, din=0xCAFEF00D → aux_rdata=0xCAFEF00D.
- Saturation and clear (CW=4): 20 conflict cycles → stat_conflicts=4'hF. Then stat_clr with a simultaneous conflict → 0.
- HRESETn pulsed low in the cycle after an aux read grant → aux_rvalid=0 immediately, stat_conflicts=0, aux_rdata=0.
